dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Data-memory bridge directly downstream of the single-cycle datapath.
- Consumes the datapath's memory address, store data and write strobe; produces load data and a stall.
- Converts single-cycle load/store intent into a req/ack bus transaction to data SRAM or peripherals.
- Posts stores through a one-entry write buffer; holds the core (stall) on loads, on a full buffer and on bus latency.

Parameters:
TIMEOUT_CYC, 64, cycles bus_req may stay high without bus_ack before the transaction is aborted (>=2)
FAULT_DATA, 32'h0000_0000, load data returned on timeout or misaligned load

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
core_addr  input  32  byte address from datapath ALU result
core_wdata  input  32  store data (register rd2)
core_we  input  1  store request (mem_write)
core_re  input  1  load request (mem_to_reg)
core_byte  input  1  1 = byte access (LDRB/STRB), 0 = word
core_rdata  output  32  load data to result mux
stall  output  1  1 = hold PC and register write this cycle
fault  output  1  one-cycle pulse on misaligned access or timeout
fault_addr  output  32  address of most recent fault, sticky until next fault
bus_req  output  1  transaction valid
bus_we  output  1  1 = write
bus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata  output  32  write data
bus_be  output  4  byte enables
bus_rdata  input  32  read data, valid with bus_ack on reads
bus_ack  input  1  transaction complete

Behaviour:
- Reset (async): state IDLE, write buffer empty, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, core_rdata=0, fault=0, fault_addr=0, timeout counter 0; stall=0 while reset held.
- Reset asserted mid-transaction drops bus_req immediately; the aborted transaction is not retried.
- States: IDLE, WDRAIN (buffered write on bus), RD (read on bus), RESP (load data valid).
- Lane rules:
  - word access: be=4'hF.
  - byte access: be=4'b0001<<addr[1:0]; store data replicated to all four lanes; load data = selected lane zero-extended to 32 bits.
- Misaligned word access (core_byte=0, addr[1:0]!=0): no bus activity, no stall; fault pulses; fault_addr<=core_addr; store dropped; load returns FAULT_DATA in the same cycle.
- Store:
  - buffer empty: capture addr/data/be at posedge, stall=0 (posted, zero-latency); next cycle enter WDRAIN, bus_req=1.
  - buffer full: stall=1 until the buffer drains; new store captured in the cycle it becomes empty.
- WDRAIN: bus_req, addr, we, wdata and be held stable until bus_ack; on ack the buffer empties and bus_req drops the same edge (back-to-back capture permitted).
- Load:
  - buffer occupied: stall=1 until drained (RAW ordering guaranteed, no forwarding).
  - otherwise enter RD next edge; bus_req=1, bus_we=0; stall=1 throughout RD.
  - on bus_ack, latch the lane-adjusted bus_rdata into core_rdata and enter RESP.
  - RESP lasts exactly one cycle with stall=0 (core commits), then IDLE; minimum load latency is 2 stall cycles + RESP.
- Stall equation: stall = (core_re & state!=RESP & aligned) | (core_we & buf_full & aligned).
- Timeout: counter counts cycles with bus_req=1 & !bus_ack; on reaching TIMEOUT_CYC, drop bus_req and pulse fault with fault_addr = bus address.
  - write: buffer discarded.
  - read: core_rdata=FAULT_DATA via RESP.
  - counter clears on ack, timeout or new transaction.
- core_we and core_re both high: store wins, load ignored (decoder never produces this).
- bus_ack outside WDRAIN/RD is ignored.

Decomposition:
- Shared package (dmem_pkg): state encoding (IDLE/WDRAIN/RD/RESP), BE_WORD=4'hF, byte-lane shift helper, load-extract function.
- One sub-module is natural: dmem_wbuf (one-entry write buffer: addr/data/be registers, full flag, capture/drain handshake).

Test Plan:
- Aligned word store 0x100<=0xCAFEBABE, ack after 3 cycles -> stall never asserted; bus_req high 3 cycles with addr 0x100, be 4'hF, we=1; buffer empty after ack.
- Store 0x100 then immediately load 0x100, bus returns 0xCAFEBABE -> stall high during drain and RD; core_rdata=0xCAFEBABE in RESP with stall=0.
- STRB 0xAB to 0x203 -> bus_addr 0x200, be 4'b1000, wdata 0xABABABAB; LDRB 0x202 with bus_rdata 0x11223344 -> core_rdata 0x00000022.
- Word load from 0x106 -> no bus_req, fault pulse, fault_addr 0x106, core_rdata=FAULT_DATA, stall=0.
- Load with bus_ack withheld -> after 64 cycles bus_req drops, fault pulses, RESP returns FAULT_DATA, stall releases.
- Reset asserted while WDRAIN pending -> bus_req falls asynchronously, all outputs at reset values, next store accepted normally.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and lane helpers for the data-memory bridge.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WDRAIN = 2'd1,
      ST_RD     = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam logic [3:0] BE_WORD = 4'hF;

   // Byte enables for an access: one lane for byte accesses, all four for words.
   function automatic logic [3:0] lane_be(input logic [1:0] off, input logic byte_acc);
      return byte_acc ? (4'b0001 << off) : BE_WORD;
   endfunction

   // Store data as driven on the bus: byte stores replicate the low byte.
   function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic byte_acc);
      return byte_acc ? {4{wdata[7:0]}} : wdata;
   endfunction

   // Load data as seen by the core: byte loads pick one lane, zero-extended.
   function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] off,
                                                input logic byte_acc);
      logic [31:0] sh;
      sh = rdata >> {off, 3'b000};
      return byte_acc ? {24'h0, sh[7:0]} : rdata;
   endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Request/acknowledge data bus between the bridge and SRAM/peripherals.
interface dmem_bridge_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                   input  bus_rdata, bus_ack);
   modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                   output bus_rdata, bus_ack);
endinterface

// File: rtl/dmem_bridge_wbuf.sv
// One-entry posted write buffer: captures a store, holds it until drained.
module dmem_wbuf (
   input  logic        clk,
   input  logic        reset,
   input  logic        cap_i,
   input  logic        clr_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  be_i,
   output logic        full_o,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   output logic [3:0]  be_o
);

   logic        full_q, full_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  be_q, be_d;

   // Capture wins over clear; the two never coincide because capture needs an empty buffer.
   always_comb begin
      full_d = full_q;
      addr_d = addr_q;
      data_d = data_q;
      be_d   = be_q;
      if (cap_i) begin
         full_d = 1'b1;
         addr_d = addr_i;
         data_d = data_i;
         be_d   = be_i;
      end else if (clr_i) begin
         full_d = 1'b0;
      end
   end

   // Buffer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         be_q   <= '0;
      end else begin
         full_q <= full_d;
         addr_q <= addr_d;
         data_q <= data_d;
         be_q   <= be_d;
      end
   end

   assign full_o = full_q;
   assign addr_o = addr_q;
   assign data_o = data_q;
   assign be_o   = be_q;

endmodule

// File: rtl/dmem_bridge.sv
// Bridge from single-cycle datapath load/store intent to a req/ack data bus.
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter logic [31:0] FAULT_DATA  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic        core_we,
   input  logic        core_re,
   input  logic        core_byte,
   output logic [31:0] core_rdata,
   output logic        stall,
   output logic        fault,
   output logic [31:0] fault_addr,
   dmem_bridge_if.master bus
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   state_e        state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [31:0]   rd_addr_q, rd_addr_d;
   logic          rd_byte_q, rd_byte_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          fault_q, fault_d;
   logic [31:0]   fault_addr_q, fault_addr_d;

   logic          aligned, mis_acc, mis_load, in_xfer, tmo_hit;
   logic          wb_cap, wb_clr, wb_full;
   logic [31:0]   wb_addr, wb_data, bus_addr_w;
   logic [3:0]    wb_be, bus_be_w;

   // Access classification, timeout detection and buffer handshake.
   always_comb begin
      aligned  = core_byte | (core_addr[1:0] == 2'b00);
      mis_acc  = (core_we | core_re) & ~aligned;
      mis_load = core_re & ~core_we & ~aligned;
      in_xfer  = (state_q == ST_WDRAIN) || (state_q == ST_RD);
      tmo_hit  = in_xfer & ~bus.bus_ack & (tmo_q == TW'(TIMEOUT_CYC - 1));
      wb_cap   = core_we & aligned & ~wb_full;
      wb_clr   = (state_q == ST_WDRAIN) & (bus.bus_ack | tmo_hit);
   end

   dmem_wbuf u_wbuf (
      .clk    (clk),
      .reset  (reset),
      .cap_i  (wb_cap),
      .clr_i  (wb_clr),
      .addr_i ({core_addr[31:2], 2'b00}),
      .data_i (store_data(core_wdata, core_byte)),
      .be_i   (lane_be(core_addr[1:0], core_byte)),
      .full_o (wb_full),
      .addr_o (wb_addr),
      .data_o (wb_data),
      .be_o   (wb_be)
   );

   // Next-state logic: drain buffered stores first, then serve loads.
   // Drain always returns through IDLE, so a load queued behind a store costs one extra stall cycle.
   always_comb begin
      state_d   = state_q;
      tmo_d     = '0;
      rd_addr_d = rd_addr_q;
      rd_byte_d = rd_byte_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (wb_cap || wb_full) begin
               state_d = ST_WDRAIN;
            end else if (core_re && !core_we && aligned) begin
               state_d   = ST_RD;
               rd_addr_d = core_addr;
               rd_byte_d = core_byte;
            end
         end
         ST_WDRAIN: begin
            if (bus.bus_ack || tmo_hit) state_d = ST_IDLE;
            else                        tmo_d   = tmo_q + TW'(1);
         end
         ST_RD: begin
            if (bus.bus_ack) begin
               rdata_d = load_extract(bus.bus_rdata, rd_addr_q[1:0], rd_byte_q);
               state_d = ST_RESP;
            end else if (tmo_hit) begin
               rdata_d = FAULT_DATA;
               state_d = ST_RESP;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Fault pulse and sticky fault address.
   always_comb begin
      fault_d      = mis_acc | tmo_hit;
      fault_addr_d = fault_addr_q;
      if (tmo_hit)      fault_addr_d = bus_addr_w;
      else if (mis_acc) fault_addr_d = core_addr;
   end

   // State, timeout counter, read latch and fault registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         tmo_q        <= '0;
         rd_addr_q    <= '0;
         rd_byte_q    <= 1'b0;
         rdata_q      <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         rd_addr_q    <= rd_addr_d;
         rd_byte_q    <= rd_byte_d;
         rdata_q      <= rdata_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   // Bus drive from the buffer during drains and from the read latch during reads.
   always_comb begin
      bus_addr_w = (state_q == ST_RD) ? {rd_addr_q[31:2], 2'b00} : wb_addr;
      bus_be_w   = (state_q == ST_RD) ? lane_be(rd_addr_q[1:0], rd_byte_q) : wb_be;
      bus.bus_req   = in_xfer;
      bus.bus_we    = (state_q == ST_WDRAIN);
      bus.bus_addr  = bus_addr_w;
      bus.bus_wdata = wb_data;
      bus.bus_be    = bus_be_w;
      stall = ~reset & aligned &
              ((core_re & ~core_we & (state_q != ST_RESP)) | (core_we & wb_full));
      core_rdata = (mis_load & ~reset) ? FAULT_DATA : rdata_q;
      fault      = fault_q;
      fault_addr = fault_addr_q;
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed scenarios plus random load/store traffic
// against a byte-array memory model and an expected-transaction queue.
module tb_dmem_bridge;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } txn_t;

   localparam logic [31:0] FD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] core_addr, core_wdata, core_rdata, fault_addr;
   logic        core_we, core_re, core_byte, stall, fault;

   dmem_bridge_if bif ();

   dmem_bridge #(.TIMEOUT_CYC(64), .FAULT_DATA(FD)) dut (
      .clk        (clk),
      .reset      (reset),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_we    (core_we),
      .core_re    (core_re),
      .core_byte  (core_byte),
      .core_rdata (core_rdata),
      .stall      (stall),
      .fault      (fault),
      .fault_addr (fault_addr),
      .bus        (bif)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          fixed_lat = 0;
   bit          hold_ack = 1'b0;
   bit          chk_bus = 1'b0;
   txn_t        expq[$];
   logic [31:0] smem[bit [31:0]];
   logic [7:0]  refm[64];
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_we;
   int unsigned req_cycles_last = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bus responder: acks after a fixed or random number of wait cycles.
   initial begin
      int unsigned cnt = 0;
      int unsigned lat = 0;
      txn_t        e;
      logic [31:0] w;
      bif.bus_ack   = 1'b0;
      bif.bus_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset || !bif.bus_req) begin
            bif.bus_ack = 1'b0;
            cnt = 0;
         end else begin
            if (cnt == 0) begin
               last_addr  = bif.bus_addr;
               last_we    = bif.bus_we;
               last_be    = bif.bus_be;
               last_wdata = bif.bus_wdata;
               lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
               if (chk_bus) begin
                  if (expq.size() == 0) begin
                     chk("unexpected_txn", bif.bus_addr, 32'hFFFF_FFFF);
                  end else begin
                     e = expq.pop_front();
                     chk("txn_we", 32'(bif.bus_we), 32'(e.we));
                     chk("txn_addr", bif.bus_addr, e.addr);
                     chk("txn_be", 32'(bif.bus_be), 32'(e.be));
                     if (e.we) chk("txn_wdata", bif.bus_wdata, e.wdata);
                  end
               end
            end
            req_cycles_last = cnt + 1;
            if (!hold_ack && cnt == lat) begin
               bif.bus_ack = 1'b1;
               w = smem.exists(bif.bus_addr) ? smem[bif.bus_addr] : 32'h0;
               if (bif.bus_we) begin
                  for (int i = 0; i < 4; i++)
                     if (bif.bus_be[i]) w[8*i +: 8] = bif.bus_wdata[8*i +: 8];
                  smem[bif.bus_addr] = w;
               end else begin
                  bif.bus_rdata = w;
               end
               cnt = 0;
            end else begin
               bif.bus_ack   = 1'b0;
               bif.bus_rdata = $urandom;
               cnt++;
            end
         end
      end
   end

   // One core access: hold it until stall drops, return what the core would commit.
   task automatic do_op(input logic we, input logic re, input logic byt,
                        input logic [31:0] a, input logic [31:0] d,
                        output int unsigned ns, output logic [31:0] rd,
                        output logic flt, output logic [31:0] fa);
      core_we = we; core_re = re; core_byte = byt; core_addr = a; core_wdata = d;
      ns = 0;
      forever begin
         @(negedge clk);
         if (!stall || ns >= 200) break;
         ns++;
      end
      chk("op_bound", 32'(ns < 200), 32'd1);
      rd = core_rdata; flt = fault; fa = fault_addr;
      @(posedge clk); #1;
      core_we = 1'b0; core_re = 1'b0;
   endtask

   // Wait for the bus to go quiet; reports fault seen at that point.
   task automatic wait_idle(output logic flt);
      int unsigned n = 0;
      forever begin
         @(negedge clk);
         if (!bif.bus_req || n >= 200) break;
         n++;
      end
      chk("idle_bound", 32'(n < 200), 32'd1);
      flt = fault;
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned ns;
      logic [31:0] rd, fa, a, d, exp;
      logic        flt;
      int unsigned k, off;

      reset = 1'b1; core_we = 1'b0; core_re = 1'b1; core_byte = 1'b0;
      core_addr = 32'h100; core_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(bif.bus_req), 0);
      chk("rst_we", 32'(bif.bus_we), 0);
      chk("rst_addr", bif.bus_addr, 0);
      chk("rst_wdata", bif.bus_wdata, 0);
      chk("rst_be", 32'(bif.bus_be), 0);
      chk("rst_rdata", core_rdata, 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_faddr", fault_addr, 0);
      chk("rst_stall", 32'(stall), 0);
      core_re = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // Posted word store, ack on third request cycle.
      fixed_lat = 2;
      do_op(1, 0, 0, 32'h100, 32'hCAFEBABE, ns, rd, flt, fa);
      chk("st_nostall", ns, 0);
      wait_idle(flt);
      chk("st_reqcyc", req_cycles_last, 3);
      chk("st_addr", last_addr, 32'h100);
      chk("st_be", 32'(last_be), 32'hF);
      chk("st_we", 32'(last_we), 1);
      chk("st_wdata", last_wdata, 32'hCAFEBABE);

      // Store then dependent load: 3 drain + 1 idle + 3 read stall cycles.
      do_op(1, 0, 0, 32'h100, 32'hCAFEBABE, ns, rd, flt, fa);
      chk("st2_nostall", ns, 0);
      do_op(0, 1, 0, 32'h100, 32'h0, ns, rd, flt, fa);
      chk("raw_stall", ns, 7);
      chk("raw_rdata", rd, 32'hCAFEBABE);

      // Minimum load latency.
      fixed_lat = 0;
      do_op(0, 1, 0, 32'h100, 32'h0, ns, rd, flt, fa);
      chk("ld_min_stall", ns, 2);

      // Byte store and byte load lanes.
      do_op(1, 0, 1, 32'h203, 32'h0000_00AB, ns, rd, flt, fa);
      chk("strb_nostall", ns, 0);
      wait_idle(flt);
      chk("strb_addr", last_addr, 32'h200);
      chk("strb_be", 32'(last_be), 32'h8);
      chk("strb_wdata", last_wdata, 32'hABABABAB);
      smem[32'h200] = 32'h11223344;
      do_op(0, 1, 1, 32'h202, 32'h0, ns, rd, flt, fa);
      chk("ldrb_rdata", rd, 32'h22);
      chk("ldrb_be", 32'(last_be), 32'h4);

      // Misaligned word load.
      do_op(0, 1, 0, 32'h106, 32'h0, ns, rd, flt, fa);
      chk("mis_stall", ns, 0);
      chk("mis_rdata", rd, FD);
      @(negedge clk);
      chk("mis_noreq", 32'(bif.bus_req), 0);
      chk("mis_fault", 32'(fault), 1);
      chk("mis_faddr", fault_addr, 32'h106);
      @(negedge clk);
      chk("mis_pulse", 32'(fault), 0);
      @(posedge clk); #1;

      // Read timeout.
      hold_ack = 1'b1;
      do_op(0, 1, 0, 32'h300, 32'h0, ns, rd, flt, fa);
      chk("rto_stall", ns, 65);
      chk("rto_rdata", rd, FD);
      chk("rto_fault", 32'(flt), 1);
      chk("rto_faddr", fa, 32'h300);
      chk("rto_reqcyc", req_cycles_last, 64);

      // Write timeout discards the buffered store.
      do_op(1, 0, 0, 32'h400, 32'h55, ns, rd, flt, fa);
      wait_idle(flt);
      chk("wto_fault", 32'(flt), 1);
      chk("wto_faddr", fault_addr, 32'h400);
      chk("wto_reqcyc", req_cycles_last, 64);
      hold_ack = 1'b0;
      do_op(0, 1, 0, 32'h400, 32'h0, ns, rd, flt, fa);
      chk("wto_nodrain", ns, 2);
      chk("wto_rdata", rd, 32'h0);

      // Reset in the middle of a drain.
      hold_ack = 1'b1;
      do_op(1, 0, 0, 32'h500, 32'h77, ns, rd, flt, fa);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mrst_req", 32'(bif.bus_req), 0);
      chk("mrst_we", 32'(bif.bus_we), 0);
      chk("mrst_addr", bif.bus_addr, 0);
      chk("mrst_be", 32'(bif.bus_be), 0);
      chk("mrst_faddr", fault_addr, 0);
      hold_ack = 1'b0;
      @(posedge clk); @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      do_op(1, 0, 0, 32'h104, 32'h12345678, ns, rd, flt, fa);
      chk("post_rst_stall", ns, 0);
      wait_idle(flt);
      chk("post_rst_addr", last_addr, 32'h104);
      chk("post_rst_wdata", last_wdata, 32'h12345678);
      chk("post_rst_reqcyc", req_cycles_last, 1);

      // Random traffic in a 64-byte window against the byte-array model.
      for (int i = 0; i < 64; i++) refm[i] = 8'h00;
      for (int i = 0; i < 16; i++) smem[32'h1000 + 4*i] = 32'h0;
      fixed_lat = -1;
      chk_bus = 1'b1;
      for (int it = 0; it < 300; it++) begin
         k   = $urandom_range(0, 5);
         off = $urandom_range(0, 63);
         d   = $urandom;
         case (k)
            0: begin
               off = off & 32'h3C; a = 32'h1000 + off;
               expq.push_back('{1'b1, a, 4'hF, d});
               for (int b = 0; b < 4; b++) refm[off + b] = d[8*b +: 8];
               do_op(1, 0, 0, a, d, ns, rd, flt, fa);
            end
            1: begin
               a = 32'h1000 + off;
               expq.push_back('{1'b1, a & ~32'h3, 4'b0001 << (off % 4), {4{d[7:0]}}});
               refm[off] = d[7:0];
               do_op(1, 0, 1, a, d, ns, rd, flt, fa);
            end
            2: begin
               off = off & 32'h3C; a = 32'h1000 + off;
               expq.push_back('{1'b0, a, 4'hF, 32'h0});
               exp = {refm[off+3], refm[off+2], refm[off+1], refm[off]};
               do_op(0, 1, 0, a, d, ns, rd, flt, fa);
               chk("rnd_ldw", rd, exp);
            end
            3: begin
               a = 32'h1000 + off;
               expq.push_back('{1'b0, a & ~32'h3, 4'b0001 << (off % 4), 32'h0});
               exp = {24'h0, refm[off]};
               do_op(0, 1, 1, a, d, ns, rd, flt, fa);
               chk("rnd_ldb", rd, exp);
            end
            default: begin
               a = 32'h1000 + (off | 32'h1);
               do_op(k == 5, k == 4, 0, a, d, ns, rd, flt, fa);
               chk("rnd_mis_stall", ns, 0);
               if (k == 4) chk("rnd_mis_rdata", rd, FD);
               @(negedge clk);
               chk("rnd_mis_fault", 32'(fault), 1);
               chk("rnd_mis_faddr", fault_addr, a);
               @(posedge clk); #1;
            end
         endcase
      end
      wait_idle(flt);
      chk("rnd_q_empty", 32'(expq.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
